fetch_sequencer: RTL and testbench

- Program-counter and fetch controller for the 8-bit pipelined core.
- Generates the instruction-memory address and registers the fetched 24-bit instruction into the IF/ID register that feeds the dependency-check stage.
- Sequences the fetch for unconditional jumps, conditional jumps resolved in execute, and a one-cycle load-use bubble.
- Keeps a saturating stall counter for performance checks.

---
 rtl/fetch_sequencer_pkg.sv | 68 ++++++
 rtl/fetch_sequencer_if.sv | 27 ++
 rtl/fetch_sequencer_load_use_detect.sv | 11 +
 rtl/fetch_sequencer.sv | 128 ++++++++++++
 tb/tb_fetch_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared constants, instruction field helpers and state encoding for the fetch sequencer.
// Field positions and opcode values define the 24-bit instruction format of the 8-bit core.
package fetch_sequencer_pkg;

  localparam int PC_W  = 8;
  localparam int INS_W = 24;
  localparam int REG_W = 5;

  localparam logic [INS_W-1:0] NOP = 24'h000000;

  localparam int OPC_LSB  = 19;
  localparam int DEST_LSB = 14;
  localparam int SRCA_LSB = 9;
  localparam int SRCB_LSB = 4;
  localparam int TGT_LSB  = 1;

  localparam logic [4:0] OP_JMP       = 5'b11000;
  localparam logic [4:0] OP_CJMP_MASK = 5'b11100;
  localparam logic [4:0] OP_CJMP_VAL  = 5'b11100;
  localparam logic [4:0] OP_LD        = 5'b10100;

  typedef logic [REG_W-1:0] reg_t;
  typedef logic [PC_W-1:0]  pc_t;
  typedef logic [INS_W-1:0] ins_t;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LD_CHK  = 2'd1,
    ST_BR_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    K_OTHER,
    K_JMP,
    K_CJMP,
    K_LD
  } kind_e;

  function automatic logic [4:0] f_opcode(input ins_t ins);
    return ins[OPC_LSB +: 5];
  endfunction

  function automatic reg_t f_dest(input ins_t ins);
    return ins[DEST_LSB +: REG_W];
  endfunction

  function automatic reg_t f_src_a(input ins_t ins);
    return ins[SRCA_LSB +: REG_W];
  endfunction

  function automatic reg_t f_src_b(input ins_t ins);
    return ins[SRCB_LSB +: REG_W];
  endfunction

  function automatic pc_t f_target(input ins_t ins);
    return ins[TGT_LSB +: PC_W];
  endfunction

  function automatic kind_e f_classify(input ins_t ins);
    logic [4:0] opc;
    opc = f_opcode(ins);
    if (opc == OP_JMP)                              return K_JMP;
    else if ((opc & OP_CJMP_MASK) == OP_CJMP_VAL)   return K_CJMP;
    else if (opc == OP_LD)                          return K_LD;
    else                                            return K_OTHER;
  endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bundle: instruction memory read, branch resolution from execute,
// and the IF/ID register outputs toward the dependency-check stage.
interface fetch_sequencer_if
  import fetch_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
);
  logic             run;
  logic [INS_W-1:0] ins_in;
  logic             br_resolved;
  logic             br_taken;
  logic [PC_W-1:0]  pc;
  logic [INS_W-1:0] ins_out;
  logic             ins_valid;
  logic             stall;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  run, ins_in, br_resolved, br_taken,
    output pc, ins_out, ins_valid, stall, stall_cnt
  );

  modport master (
    output run, ins_in, br_resolved, br_taken,
    input  pc, ins_out, ins_valid, stall, stall_cnt
  );
endinterface

// File: rtl/fetch_sequencer_load_use_detect.sv
// Load-use hazard: the instruction being fetched reads the register the previous load writes.
module load_use_detect
  import fetch_sequencer_pkg::*;
(
  input  reg_t held_dest,
  input  reg_t src_a,
  input  reg_t src_b,
  output logic hazard
);
  assign hazard = (src_a == held_dest) || (src_b == held_dest);
endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: issues imem[pc] into the IF/ID register,
// handling jumps, conditional-jump waits, one-cycle load-use bubbles and a stall counter.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  fetch_sequencer_if.slave bus
);

  state_e           state_q,     state_d;
  pc_t              pc_q,        pc_d;
  ins_t             ins_out_q,   ins_out_d;
  logic             ins_valid_q, ins_valid_d;
  logic             stall_q,     stall_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  pc_t              tgt_q,       tgt_d;
  reg_t             ld_dest_q,   ld_dest_d;

  logic  hazard;
  logic  issue;
  logic  bubble;
  kind_e kind;
  pc_t   pc_inc;

  load_use_detect u_load_use (
    .held_dest (ld_dest_q),
    .src_a     (f_src_a(bus.ins_in)),
    .src_b     (f_src_b(bus.ins_in)),
    .hazard    (hazard)
  );

  assign kind   = f_classify(bus.ins_in);
  assign pc_inc = pc_q + PC_W'(1);

  // NOTE: every _d gets a default before any branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    tgt_d       = tgt_q;
    ld_dest_d   = ld_dest_q;
    cnt_d       = cnt_q;
    ins_out_d   = NOP;
    ins_valid_d = 1'b0;
    stall_d     = 1'b0;
    issue       = 1'b0;
    bubble      = 1'b0;

    unique case (state_q)
      ST_RUN:    issue = bus.run;
      ST_LD_CHK: begin
        if (bus.run) begin
          if (hazard) begin
            bubble  = 1'b1;
            state_d = ST_RUN;
          end else begin
            issue = 1'b1;
          end
        end
      end
      ST_BR_WAIT: begin
        bubble = bus.run;
        // Resolution is honoured even while frozen so execute never has to re-send it.
        if (bus.br_resolved) begin
          pc_d    = bus.br_taken ? tgt_q : pc_inc;
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_RUN;
    endcase

    if (bubble) begin
      stall_d = 1'b1;
      cnt_d   = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

    if (issue) begin
      ins_out_d   = bus.ins_in;
      ins_valid_d = 1'b1;
      state_d     = ST_RUN;
      unique case (kind)
        K_JMP:  pc_d = f_target(bus.ins_in);
        K_CJMP: begin
          tgt_d   = f_target(bus.ins_in);
          state_d = ST_BR_WAIT;
        end
        K_LD: begin
          pc_d      = pc_inc;
          ld_dest_d = f_dest(bus.ins_in);
          state_d   = ST_LD_CHK;
        end
        default: pc_d = pc_inc;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_RUN;
      pc_q        <= '0;
      ins_out_q   <= NOP;
      ins_valid_q <= 1'b0;
      stall_q     <= 1'b0;
      cnt_q       <= '0;
      tgt_q       <= '0;
      ld_dest_q   <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ins_out_q   <= ins_out_d;
      ins_valid_q <= ins_valid_d;
      stall_q     <= stall_d;
      cnt_q       <= cnt_d;
      tgt_q       <= tgt_d;
      ld_dest_q   <= ld_dest_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ins_out   = ins_out_q;
  assign bus.ins_valid = ins_valid_q;
  assign bus.stall     = stall_q;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a cycle-level reference model queues the expected
// IF/ID outputs, and a monitor compares them one edge at a time against the DUT.
module tb_fetch_sequencer;

  localparam int CNT_W   = 5;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam logic [4:0] OPC_ADD  = 5'b00001;
  localparam logic [4:0] OPC_SUB  = 5'b00010;
  localparam logic [4:0] OPC_ST   = 5'b10101;
  localparam logic [4:0] OPC_JMP  = 5'b11000;
  localparam logic [4:0] OPC_CJ0  = 5'b11100;
  localparam logic [4:0] OPC_CJ3  = 5'b11111;
  localparam logic [4:0] OPC_LD   = 5'b10100;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  fetch_sequencer_if #(.CNT_W(CNT_W)) bus ();

  fetch_sequencer #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [23:0] imem [256];
  assign bus.ins_in = imem[bus.pc];

  always #5 clk = ~clk;

  typedef struct {
    int          pc;
    logic [23:0] ins;
    bit          valid;
    bit          stall;
    int          cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: architectural meaning only.
  int          m_pc;
  bit          m_wait_branch;
  int          m_branch_tgt;
  int          m_load_dest;   // -1 when the previous issue was not a load
  int          m_cnt;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [23:0] alu(input logic [4:0] op, input int d, input int a, input int b);
    logic [4:0] dd, aa, bb;
    dd = 5'(d); aa = 5'(a); bb = 5'(b);
    return {op, dd, aa, bb, 4'b0000};
  endfunction

  function automatic logic [23:0] jump(input logic [4:0] op, input int tgt);
    logic [7:0] t;
    t = 8'(tgt);
    return {op, 10'b0, t, 1'b0};
  endfunction

  task automatic fill_filler();
    for (int i = 0; i < 256; i++) imem[i] = alu(OPC_ADD, 7, 6, 5);
  endtask

  task automatic model_step(input bit r, input bit br, input bit tk);
    logic [23:0] w;
    logic [4:0]  op;
    exp_t        e;
    bit          bubble;
    w = imem[m_pc];
    op = w[23:19];
    e.ins = 24'h0; e.valid = 0; e.stall = 0;
    bubble = 0;
    if (m_wait_branch) begin
      bubble = r;
      if (br) begin
        m_pc = tk ? m_branch_tgt : (m_pc + 1) % 256;
        m_wait_branch = 0;
      end
    end else if (r) begin
      if (m_load_dest >= 0 && (int'(w[13:9]) == m_load_dest || int'(w[8:4]) == m_load_dest)) begin
        bubble = 1;
        m_load_dest = -1;
      end else begin
        e.ins = w;
        e.valid = 1;
        m_load_dest = -1;
        if (op == OPC_JMP) m_pc = int'(w[8:1]);
        else if (op[4:2] == 3'b111) begin
          m_wait_branch = 1;
          m_branch_tgt = int'(w[8:1]);
        end else begin
          if (op == OPC_LD) m_load_dest = int'(w[18:14]);
          m_pc = (m_pc + 1) % 256;
        end
      end
    end
    if (bubble) begin
      e.stall = 1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
    e.pc  = m_pc;
    e.cnt = m_cnt;
    exp_q.push_back(e);
  endtask

  // Called at a falling edge; returns at the next falling edge with the edge's result visible.
  task automatic step(input bit r, input bit br, input bit tk);
    bus.run = r;
    bus.br_resolved = br;
    bus.br_taken = tk;
    model_step(r, br, tk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    exp_t e;
    reset = 1'b1;
    #1;
    check("rst_pc",        bus.pc,        0);
    check("rst_ins_valid", bus.ins_valid, 0);
    check("rst_stall",     bus.stall,     0);
    check("rst_cnt",       bus.stall_cnt, 0);
    check("rst_ins_out",   bus.ins_out,   0);
    m_pc = 0; m_wait_branch = 0; m_branch_tgt = 0; m_load_dest = -1; m_cnt = 0;
    e.pc = 0; e.ins = 24'h0; e.valid = 0; e.stall = 0; e.cnt = 0;
    exp_q.push_back(e);
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [23:0] rand_word();
    int k;
    k = $urandom_range(0, 9);
    if (k == 6) return jump(OPC_JMP, $urandom_range(0, 255));
    if (k == 7) return jump(5'b11100 | 5'($urandom_range(0, 3)), $urandom_range(0, 255));
    if (k >= 8) return alu(OPC_LD, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    case (k % 3)
      0:       return alu(OPC_ADD, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      1:       return alu(OPC_SUB, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      default: return alu(OPC_ST,  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    endcase
  endfunction

  // Monitor: one expected IF/ID state per clock edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("sb_pc",        bus.pc,        mon_e.pc);
      check("sb_ins_out",   bus.ins_out,   mon_e.ins);
      check("sb_ins_valid", bus.ins_valid, mon_e.valid);
      check("sb_stall",     bus.stall,     mon_e.stall);
      check("sb_stall_cnt", bus.stall_cnt, mon_e.cnt);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.run = 1'b0;
    bus.br_resolved = 1'b0;
    bus.br_taken = 1'b0;
    fill_filler();
    @(negedge clk);

    // Sequential flow
    do_reset();
    repeat (4) step(1, 0, 0);
    check("seq_pc",    bus.pc,        4);
    check("seq_valid", bus.ins_valid, 1);
    check("seq_cnt",   bus.stall_cnt, 0);

    // Unconditional jump: no bubble
    imem[2] = jump(OPC_JMP, 8'h40);
    do_reset();
    repeat (3) step(1, 0, 0);
    check("jmp_pc",    bus.pc,    8'h40);
    check("jmp_stall", bus.stall, 0);
    step(1, 0, 0);
    check("jmp_next_pc", bus.pc, 8'h41);
    fill_filler();

    // Conditional jump taken after 3 bubbles
    imem[5] = jump(OPC_CJ0, 8'h10);
    do_reset();
    repeat (6) step(1, 0, 0);
    check("cj_hold_pc", bus.pc, 5);
    repeat (2) step(1, 0, 0);
    check("cj_wait_pc",    bus.pc,    5);
    check("cj_wait_stall", bus.stall, 1);
    step(1, 1, 1);
    check("cj_taken_pc",  bus.pc,        8'h10);
    check("cj_taken_cnt", bus.stall_cnt, 3);

    // Conditional jump not taken
    imem[5] = jump(OPC_CJ3, 8'h10);
    do_reset();
    repeat (8) step(1, 0, 0);
    step(1, 1, 0);
    check("cj_ntaken_pc",  bus.pc,        6);
    check("cj_ntaken_cnt", bus.stall_cnt, 3);
    fill_filler();

    // Load-use hazard, then freeze with a nonzero counter
    imem[0] = alu(OPC_LD, 3, 0, 0);
    imem[1] = alu(OPC_ADD, 1, 2, 3);
    do_reset();
    step(1, 0, 0);
    check("ld_pc", bus.pc, 1);
    step(1, 0, 0);
    check("ld_bubble_stall", bus.stall, 1);
    check("ld_bubble_pc",    bus.pc,    1);
    step(1, 0, 0);
    check("ld_issue_pc",  bus.pc,      2);
    check("ld_issue_ins", bus.ins_out, alu(OPC_ADD, 1, 2, 3));
    check("ld_cnt",       bus.stall_cnt, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    check("frz_pc",    bus.pc,        2);
    check("frz_stall", bus.stall,     0);
    check("frz_valid", bus.ins_valid, 0);
    check("frz_cnt",   bus.stall_cnt, 1);

    // Load without a hazard
    imem[1] = alu(OPC_ADD, 1, 4, 5);
    do_reset();
    repeat (2) step(1, 0, 0);
    check("ld_nohaz_pc",  bus.pc,        2);
    check("ld_nohaz_cnt", bus.stall_cnt, 0);
    fill_filler();

    // Asynchronous reset while waiting on a branch
    imem[2] = jump(OPC_CJ0, 8'h30);
    repeat (4) step(1, 0, 0);
    do_reset();
    step(1, 0, 0);
    check("post_rst_pc", bus.pc, 1);
    step(1, 1, 1);
    check("stray_br_pc", bus.pc, 2);
    fill_filler();

    // Counter saturation
    imem[0] = jump(OPC_CJ0, 8'h20);
    do_reset();
    repeat (41) step(1, 0, 0);
    check("sat_cnt", bus.stall_cnt, CNT_MAX);
    step(1, 1, 0);
    check("sat_pc",       bus.pc,        1);
    check("sat_cnt_hold", bus.stall_cnt, CNT_MAX);

    // Randomized programs and control
    for (int blk = 0; blk < 20; blk++) begin
      for (int i = 0; i < 256; i++) imem[i] = rand_word();
      do_reset();
      for (int c = 0; c < 150; c++)
        step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
